// File: rtl/el2_trace_sink.sv
// el2_trace_sink: captures retired-instruction trace records into a FIFO and
// serializes each record as a header word followed by address, instruction
// and (optionally) trap-value words on a valid/ready output stream.
//
// Optional feature: define EL2_TRACE_SINK_TVAL_EN to store the trap value and
// emit it as a fourth word for records carrying an exception or interrupt.
// Without the macro every record is exactly three words.
//
// Output handshake: a word is transferred on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises, out_valid and out_data hold until
// that transfer happens; out_valid never depends on out_ready.
module el2_trace_sink #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic        trace_rv_i_valid_ip,
    input  logic [31:0] trace_rv_i_insn_ip,
    input  logic [31:0] trace_rv_i_address_ip,
    input  logic [31:0] trace_rv_i_tval_ip,
    input  logic        trace_rv_i_exception_ip,
    input  logic        trace_rv_i_interrupt_ip,
    input  logic [4:0]  trace_rv_i_ecause_ip,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt,
    output logic [2:0]  fsm_state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
`ifdef EL2_TRACE_SINK_TVAL_EN
        logic [31:0] tval;
`endif
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
    } rec_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        ADDR = 3'd2,
        INSN = 3'd3,
        TVAL = 3'd4
    } state_t;

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    state_t        state;
    state_t        next_state;
    rec_t          hold;
    rec_t          head;
    rec_t          in_rec;
    logic [31:0]   hdr_reg;
    logic [7:0]    seq;
    logic [7:0]    pop_words;
    logic [7:0]    drop_base;

    logic          push;
    logic          pop;
    logic          drop;
    logic          accept;
    logic          hdr_accept;
    logic          need_tval;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push       = trace_en & trace_rv_i_valid_ip & ~fifo_full;
    assign drop       = trace_en & trace_rv_i_valid_ip & fifo_full;
    assign accept     = out_valid & out_ready;
    assign hdr_accept = accept & (state == HDR);
    assign head       = mem[rd_ptr];
    assign fsm_state  = state;

    // Pack incoming trace inputs into a record.
    always_comb begin
        in_rec        = '0;
        in_rec.insn   = trace_rv_i_insn_ip;
        in_rec.addr   = trace_rv_i_address_ip;
        in_rec.exc    = trace_rv_i_exception_ip;
        in_rec.intr   = trace_rv_i_interrupt_ip;
        in_rec.ecause = trace_rv_i_ecause_ip;
`ifdef EL2_TRACE_SINK_TVAL_EN
        in_rec.tval   = trace_rv_i_tval_ip;
`endif
    end

`ifdef EL2_TRACE_SINK_TVAL_EN
    assign need_tval = hold.exc | hold.intr;
    assign pop_words = (head.exc | head.intr) ? 8'd4 : 8'd3;
`else
    logic unused_tval;
    assign unused_tval = ^trace_rv_i_tval_ip;
    assign need_tval   = 1'b0;
    assign pop_words   = 8'd3;
`endif

    // Record storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Serializer next state and pop decision; the last word of a record pops
    // the next one on the same edge so records stream without a bubble.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: if (accept) next_state = ADDR;
            ADDR: if (accept) next_state = INSN;
            INSN: begin
                if (accept) begin
                    if (need_tval) begin
                        next_state = TVAL;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = HDR;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            TVAL: begin
                if (accept) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = HDR;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Holding register and header snapshot, captured when a record is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            hdr_reg <= '0;
        end else if (pop) begin
            hold    <= head;
            hdr_reg <= {head.exc, head.intr, (drop_cnt != 8'd0), head.ecause,
                        drop_cnt, seq, pop_words};
        end
    end

    // Drops already reported in an accepted header are subtracted; new drops
    // in the same cycle still count.
    always_comb begin
        drop_base = hdr_accept ? (drop_cnt - hdr_reg[23:16]) : drop_cnt;
    end

    // Sequence number and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (hdr_accept) seq <= seq + 8'd1;
            drop_cnt <= (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
        end
    end

    // Output word select; everything comes from registers so it holds under stall.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 32'd0;
        case (state)
            HDR:  begin out_valid = 1'b1; out_data = hdr_reg;   end
            ADDR: begin out_valid = 1'b1; out_data = hold.addr; end
            INSN: begin out_valid = 1'b1; out_data = hold.insn; end
            TVAL: begin
                out_valid = 1'b1;
`ifdef EL2_TRACE_SINK_TVAL_EN
                out_data  = hold.tval;
`endif
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_el2_trace_sink.sv
// Directed bench for el2_trace_sink (DEPTH = 8). Expected words are computed
// by hand from the header layout and record contents.
module tb_el2_trace_sink;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        trace_rv_i_valid_ip;
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic [31:0] trace_rv_i_tval_ip;
    logic        trace_rv_i_exception_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic [2:0]  fsm_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    el2_trace_sink #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .trace_en                (trace_en),
        .trace_rv_i_valid_ip     (trace_rv_i_valid_ip),
        .trace_rv_i_insn_ip      (trace_rv_i_insn_ip),
        .trace_rv_i_address_ip   (trace_rv_i_address_ip),
        .trace_rv_i_tval_ip      (trace_rv_i_tval_ip),
        .trace_rv_i_exception_ip (trace_rv_i_exception_ip),
        .trace_rv_i_interrupt_ip (trace_rv_i_interrupt_ip),
        .trace_rv_i_ecause_ip    (trace_rv_i_ecause_ip),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .fifo_empty              (fifo_empty),
        .fifo_full               (fifo_full),
        .drop_cnt                (drop_cnt),
        .fsm_state               (fsm_state)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rec(input logic [31:0] addr, input logic [31:0] insn,
                             input logic [31:0] tval, input logic exc,
                             input logic intr, input logic [4:0] ecause);
        trace_rv_i_valid_ip     = 1'b1;
        trace_rv_i_address_ip   = addr;
        trace_rv_i_insn_ip      = insn;
        trace_rv_i_tval_ip      = tval;
        trace_rv_i_exception_ip = exc;
        trace_rv_i_interrupt_ip = intr;
        trace_rv_i_ecause_ip    = ecause;
    endtask

    task automatic idle_in();
        trace_en                = 1'b1;
        trace_rv_i_valid_ip     = 1'b0;
        trace_rv_i_address_ip   = 32'd0;
        trace_rv_i_insn_ip      = 32'd0;
        trace_rv_i_tval_ip      = 32'd0;
        trace_rv_i_exception_ip = 1'b0;
        trace_rv_i_interrupt_ip = 1'b0;
        trace_rv_i_ecause_ip    = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic stalled_prev;
        logic [31:0] prev_data;

        out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_state", fsm_state, 0);

        // Single record, no trap: header at N+2, then address, instruction
        out_ready = 1'b1;
        drive_rec(32'h0000_1000, 32'h0000_0013, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle_in();
        chk("lat_n1_valid", out_valid, 0);
        chk("lat_n1_not_empty", fifo_empty, 0);
        tick();
        chk("lat_n2_valid", out_valid, 1);
        chk("single_hdr", out_data, 32'h0000_0003);
        tick();
        chk("single_addr", out_data, 32'h0000_1000);
        tick();
        chk("single_insn", out_data, 32'h0000_0013);
        tick();
        chk("single_done_valid", out_valid, 0);
        chk("single_done_empty", fifo_empty, 1);

        // Exception record with trap value
        do_reset();
        out_ready = 1'b1;
        drive_rec(32'h0000_2000, 32'h0000_0073, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd5);
        tick();
        idle_in();
        tick();
`ifdef EL2_TRACE_SINK_TVAL_EN
        chk("exc_hdr", out_data, 32'h8500_0004);
`else
        chk("exc_hdr", out_data, 32'h8500_0003);
`endif
        tick();
        chk("exc_addr", out_data, 32'h0000_2000);
        tick();
        chk("exc_insn", out_data, 32'h0000_0073);
        tick();
`ifdef EL2_TRACE_SINK_TVAL_EN
        chk("exc_tval", out_data, 32'hDEAD_BEEF);
        tick();
`endif
        chk("exc_done_valid", out_valid, 0);

        // Overflow: record 0 moves to the holding register, records 1..8 fill
        // the FIFO, records 9..11 are dropped; a disabled record is not a drop.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            drive_rec(32'h100 + k, 32'h200 + k, 32'd0, 1'b0, 1'b0, 5'd0);
            tick();
        end
        trace_en = 1'b0;
        tick();
        chk("ovf_drop_cnt", drop_cnt, 3);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_stall_valid", out_valid, 1);
        chk("ovf_stall_hdr0", out_data, 32'h0000_0003);
        idle_in();
        out_ready = 1'b1;
        tick();
        chk("ovf_addr0", out_data, 32'h0000_0100);
        tick();
        chk("ovf_insn0", out_data, 32'h0000_0200);
        tick();
        chk("ovf_hdr1", out_data, 32'h2003_0103);
        chk("ovf_full_after_pop", fifo_full, 0);
        tick();
        chk("ovf_drop_cleared", drop_cnt, 0);
        chk("ovf_addr1", out_data, 32'h0000_0101);
        tick();
        chk("ovf_insn1", out_data, 32'h0000_0201);
        for (int k = 2; k <= DEPTH; k++) begin
            tick();
            chk("b2b_hdr", out_data, (k << 8) | 3);
            tick();
            chk("b2b_addr", out_data, 32'h100 + k);
            tick();
            chk("b2b_insn", out_data, 32'h200 + k);
        end
        tick();
        chk("b2b_done_valid", out_valid, 0);
        chk("b2b_done_empty", fifo_empty, 1);

        // Toggling out_ready: words held while stalled, none lost or repeated
        do_reset();
        exp_q = {32'h0000_0003, 32'h0000_00A0, 32'h0000_00B0,
                 32'h0000_0103, 32'h0000_00A1, 32'h0000_00B1};
        drive_rec(32'hA0, 32'hB0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        drive_rec(32'hA1, 32'hB1, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle_in();
        stalled_prev = 1'b0;
        prev_data    = 32'd0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            out_ready = c[0];
            if (out_valid) begin
                chk("tog_word", out_data, exp_q[0]);
                if (stalled_prev) chk("tog_stable", out_data, prev_data);
                if (out_ready) void'(exp_q.pop_front());
            end
            stalled_prev = out_valid & ~out_ready;
            prev_data    = out_data;
            tick();
        end
        chk("tog_all_words", exp_q.size(), 0);
        chk("tog_done_valid", out_valid, 0);

        // Reset in the middle of a record
        do_reset();
        out_ready = 1'b1;
        drive_rec(32'h300, 32'h400, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        drive_rec(32'h301, 32'h401, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle_in();
        chk("mid_hdr", out_data, 32'h0000_0003);
        tick();
        chk("mid_addr", out_data, 32'h0000_0300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_data", out_data, 0);
        drive_rec(32'h500, 32'h600, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle_in();
        tick();
        chk("mid_new_valid", out_valid, 1);
        chk("mid_new_hdr_seq0", out_data, 32'h0000_0003);
        tick();
        chk("mid_new_addr", out_data, 32'h0000_0500);
        tick();
        chk("mid_new_insn", out_data, 32'h0000_0600);
        tick();
        chk("mid_new_done", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
